// File: rtl/alu_core.sv
// rtl/alu_core.sv - 32-bit integer ALU: pass, add, sub, signed compare; result registered one cycle after inputs.
module alu_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2:0]            ctrl,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] out
);

    localparam logic [2:0] OP_ID0  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_EQ   = 3'd3;
    localparam logic [2:0] OP_LT   = 3'd4;
    localparam logic [2:0] OP_GE   = 3'd5;

    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  w_eq;
    logic                  w_lt;

    // Compare directly on signed operands so overflow of in0-in1 cannot flip the answer.
    assign w_eq = (in0 == in1);
    assign w_lt = ($signed(in0) < $signed(in1));

    always_comb begin
        w_result = '0;
        case (ctrl)
            OP_ID0:  w_result = in0;
            OP_ADD:  w_result = in0 + in1;
            OP_SUB:  w_result = in0 - in1;
            OP_EQ:   w_result = {{(DATA_WIDTH-1){1'b0}}, w_eq};
            OP_LT:   w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            OP_GE:   w_result = {{(DATA_WIDTH-1){1'b0}}, ~w_lt};
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out <= '0;
        end else begin
            r_out <= w_result;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - table-driven, corner-sequence and randomized checks of alu_core against an arithmetic reference model.
module tb_alu_core;

    logic        clk;
    logic        rstn;
    logic [2:0]  ctrl;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] out;

    int n_tests;
    int n_fail;

    alu_core #(.DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .ctrl (ctrl),
        .in0  (in0),
        .in1  (in1),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference: operands become plain integers; wrap is taken modulo 2^32 afterwards.
    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, r;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = a[31] ? ua - 64'sd4294967296 : ua;
        sb = b[31] ? ub - 64'sd4294967296 : ub;
        case (c)
            3'd0:    r = ua;
            3'd1:    r = (ua + ub) % 64'sd4294967296;
            3'd2:    r = (ua - ub + 64'sd4294967296) % 64'sd4294967296;
            3'd3:    r = (ua == ub) ? 1 : 0;
            3'd4:    r = (sa < sb) ? 1 : 0;
            3'd5:    r = (sa >= sb) ? 1 : 0;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: out=%h expected=%h (ctrl=%0d in0=%h in1=%h)", name, got, want, ctrl, in0, in1);
        end
    endtask

    task automatic apply(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        ctrl = c;
        in0  = a;
        in1  = b;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    task automatic add_vec(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        v.c = c; v.a = a; v.b = b; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pos [8];
        logic [31:0] exp_neg [8];
        n_tests = 0;
        n_fail  = 0;

        exp_pos = '{32'd415, 32'd1037, 32'hFFFFFF31, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        exp_neg = '{32'd12, 32'd7, 32'd17, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++) add_vec(3'(i), 32'd415, 32'd622, exp_pos[i]);
        for (int i = 0; i < 8; i++) add_vec(3'(i), 32'd12, 32'hFFFFFFFB, exp_neg[i]);
        add_vec(3'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1);
        add_vec(3'd4, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0);
        add_vec(3'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1);
        add_vec(3'd1, 32'hFFFFFFFF, 32'd1, 32'd0);
        add_vec(3'd2, 32'd0, 32'd1, 32'hFFFFFFFF);
        add_vec(3'd4, 32'h7FFFFFFF, 32'h80000000, 32'd0);
        add_vec(3'd5, 32'h7FFFFFFF, 32'h80000000, 32'd1);
        add_vec(3'd2, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF);
        add_vec(3'd4, 32'h80000000, 32'h7FFFFFFF, 32'd1);
        add_vec(3'd5, 32'h80000000, 32'h7FFFFFFF, 32'd0);
        add_vec(3'd3, 32'h80000000, 32'h7FFFFFFF, 32'd0);

        rstn = 1'b0;
        ctrl = 3'd1;
        in0  = 32'd415;
        in1  = 32'd622;
        #2;
        check("reset_state", out, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", out, 32'd0);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_after_release", out, 32'd1037);

        // Asynchronous reset pulse mid-cycle: out must clear without a clock edge.
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_immediate", out, 32'd0);
        @(posedge clk);
        #1;
        check("reset_low_across_edge", out, 32'd0);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("release_first_edge", out, 32'd1037);

        foreach (vecs[i]) begin
            apply(vecs[i].c, vecs[i].a, vecs[i].b);
            check($sformatf("table[%0d]", i), out, vecs[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            logic [2:0]  c;
            logic [31:0] a, b;
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = a;
            if (i % 4 == 1) a = {1'b1, a[30:0]};
            apply(c, a, b);
            check($sformatf("b2b[%0d]", i), out, model(c, a, b));
        end

        for (int i = 0; i < 200; i++) begin
            logic [2:0]  c;
            logic [31:0] a, b;
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            apply(c, a, b);
            check($sformatf("rand[%0d]", i), out, model(c, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_core.md
# alu_core

`alu_core` is the 32-bit integer ALU of the distributed processor core. It computes pass-through, add, subtract and signed-compare operations on two operands, selected by a 3-bit control code. The operands come from the register file or an immediate, and the result returns to the register file or branch logic. The result is registered: it appears one clock after the operands and control are presented.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width. All arithmetic and compare rules below are stated for this width.

Ports:
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `ctrl`, input, 3: operation select.
- `in0`, input, `DATA_WIDTH`: operand 0, two's-complement.
- `in1`, input, `DATA_WIDTH`: operand 1, two's-complement.
- `out`, output, `DATA_WIDTH`: registered result.

## Operation
Operation by `ctrl` value:
- 0 (ID0): `out` = `in0`.
- 1 (ADD): `out` = `in0 + in1`, modulo 2^`DATA_WIDTH`.
- 2 (SUB): `out` = `in0 - in1`, modulo 2^`DATA_WIDTH`.
- 3 (EQ): `out` = 1 if `in0 == in1`, else 0.
- 4 (LT): `out` = 1 if `in0 < in1` as signed values, else 0.
- 5 (GE): `out` = 1 if `in0 >= in1` as signed values, else 0.
- 6 (ZERO): `out` = 0.
- 7 (reserved): `out` = 0.

Arithmetic and width rules:
- ADD and SUB wrap silently: no saturation and no overflow flag.
- Compare results are zero-extended to full width, so bits [`DATA_WIDTH`-1:1] are 0.
- LT and GE use true signed comparison. This must hold even when the subtraction overflows, e.g. `in0` = 0x7FFFFFFF and `in1` = 0x80000000 gives LT = 0, GE = 1.

Implementation structure:
- The combinational result is computed from the current `ctrl`, `in0` and `in1`.
- That result is captured into the output register on every rising edge. There is no enable and no handshake.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at rising edge N produce `out` valid after edge N, and `out` holds until edge N+1.
- Throughput: one operation per cycle. `ctrl` and operands may change every cycle.
- Reset:
  - `rstn` low forces `out` to 0 immediately, without waiting for a clock edge.
  - `out` stays 0 while `rstn` is low, whatever the inputs do.
- Reset release:
  - The first rising edge with `rstn` high captures the inputs present at that edge.
  - Deassertion is asynchronous at the port. The integrating design synchronizes it to `clk`.
- Reset mid-operation: any in-flight result is discarded, `out` goes to 0, and there is no recovery of the lost result.
- Inputs must be stable within the setup/hold window of `clk`. No other constraints apply.

## Test plan
- Reset check:
  - Drive `in0`=415, `in1`=622, `ctrl`=1 and pulse `rstn` low between clock edges -> `out` goes to 0 immediately and stays 0 while low.
  - After release, the first edge -> `out` = 1037.
- Sweep with positive operands: `in0`=415, `in1`=622, `ctrl` stepped 0..7 one per cycle -> `out` sequence, each one cycle after its `ctrl`:
  - 415, 1037, 0xFFFFFF31 (-207), 0, 1, 0, 0, 0.
- Sweep with a negative operand: `in0`=12, `in1`=-5 (0xFFFFFFFB), `ctrl` stepped 0..7 -> `out` sequence:
  - 12, 7, 17, 0, 0 (signed, not unsigned), 1, 0, 0.
- Equality and wrap:
  - `in0`=`in1`=0xDEADBEEF -> EQ = 1, LT = 0, GE = 1.
  - `in0`=0xFFFFFFFF, `in1`=1 -> ADD = 0.
  - `in0`=0, `in1`=1 -> SUB = 0xFFFFFFFF.
- Signed overflow compare:
  - `in0`=0x7FFFFFFF, `in1`=0x80000000 -> LT = 0, GE = 1, SUB = 0xFFFFFFFF.
  - Swapped operands -> LT = 1, GE = 0.
- Back-to-back operations: change `ctrl` and operands every cycle over 16 random vectors -> each `out` matches the reference model of the previous cycle's inputs, with no bubbles.
